// File: rtl/dram_rw_test_sequencer.sv
// Automated row sweep for the 16-core DRAM write/read engine: write a row pattern,
// read it back, compare all 16 core bytes and report pass/fail, error count and first bad row.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for start, results held
// SETUP_W  | write address/data/model driven, settling before strobe
// STROBE_W | one-cycle io_en for the write
// WAIT_W   | waiting for a wt_done rising edge (timeout/abort exit)
// SETUP_R  | read address/model driven, settling before strobe
// STROBE_R | one-cycle io_en for the read
// WAIT_R   | waiting for a rd_done rising edge (timeout/abort exit)
// CHECK    | compare rd_data bytes against the row pattern
// NEXT     | advance row or finish
// FINISH   | one-cycle done pulse, pass resolved
module dram_rw_test_sequencer #(
   parameter int unsigned SETUP_CYC   = 4,
   parameter int unsigned TIMEOUT_CYC = 65535,
   parameter logic [7:0]  SEED        = 8'h55
) (
   input  logic           clk_100m,
   input  logic           rst_n_locked,
   input  logic           start,
   input  logic           abort,
   input  logic [5:0]     cfg_last_row,
   output logic           io_en,
   output logic [1:0]     io_model,
   output logic [5:0]     wwl_add,
   output logic [5:0]     rwl_dec_add,
   output logic [63:0]    wbl_data,
   input  logic           wt_done,
   input  logic           rd_done,
   input  logic [127:0]   rd_data,
   output logic           busy,
   output logic           done,
   output logic           pass,
   output logic [11:0]    err_cnt,
   output logic [5:0]     fail_row,
   output logic           timeout
);

   localparam int unsigned TMR_MAX = (TIMEOUT_CYC > SETUP_CYC) ? TIMEOUT_CYC : SETUP_CYC;
   localparam int          TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(SETUP_CYC - 1);
   localparam logic [TMR_W-1:0] TO_LD    = TMR_W'(TIMEOUT_CYC - 1);

   typedef enum logic [3:0] {
      IDLE, SETUP_W, STROBE_W, WAIT_W, SETUP_R, STROBE_R, WAIT_R, CHECK, NEXT, FINISH
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [5:0]         r_row;
   logic [5:0]         w_row_nxt;
   logic [5:0]         r_last_row;
   logic [TMR_W-1:0]   r_tmr;
   logic               r_wt_prev;
   logic               r_rd_prev;
   logic               r_abort;
   logic [11:0]        r_err_cnt;
   logic [5:0]         r_fail_row;
   logic               r_fail_seen;
   logic               r_timeout;
   logic               r_pass;
   logic [1:0]         r_io_model;
   logic [5:0]         r_wwl_add;
   logic [5:0]         r_rwl_dec_add;
   logic [63:0]        r_wbl_data;

   logic               w_start_acc;
   logic               w_abort_any;
   logic               w_wt_rise;
   logic               w_rd_rise;
   logic               w_tmr_tc;
   logic               w_to_hit;
   logic [7:0]         w_pat;
   logic [4:0]         w_mis_cnt;
   logic [12:0]        w_err_sum;

   assign w_abort_any = r_abort | abort;
   assign w_wt_rise   = wt_done & ~r_wt_prev;
   assign w_rd_rise   = rd_done & ~r_rd_prev;
   assign w_tmr_tc    = (r_tmr == '0);
   assign w_pat       = SEED ^ {2'b00, r_row};
   assign w_err_sum   = {1'b0, r_err_cnt} + 13'(w_mis_cnt);

   // A wait phase times out only when neither abort nor the completion edge claims the cycle.
   assign w_to_hit = ((r_state == WAIT_W) && !w_abort_any && !w_wt_rise && w_tmr_tc) ||
                     ((r_state == WAIT_R) && !w_abort_any && !w_rd_rise && w_tmr_tc);

   always_comb begin
      w_mis_cnt = '0;
      for (int k = 0; k < 16; k++) begin
         if (rd_data[8*k +: 8] != w_pat) w_mis_cnt = w_mis_cnt + 5'd1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_row_nxt   = r_row;
      w_start_acc = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_start_acc = 1'b1;
               w_row_nxt   = '0;
               w_state_nxt = SETUP_W;
            end
         end
         SETUP_W:  if (w_tmr_tc) w_state_nxt = STROBE_W;
         STROBE_W: w_state_nxt = WAIT_W;
         WAIT_W: begin
            if (w_abort_any)    w_state_nxt = FINISH;
            else if (w_wt_rise) w_state_nxt = SETUP_R;
            else if (w_tmr_tc)  w_state_nxt = FINISH;
         end
         SETUP_R:  if (w_tmr_tc) w_state_nxt = STROBE_R;
         STROBE_R: w_state_nxt = WAIT_R;
         WAIT_R: begin
            if (w_abort_any)    w_state_nxt = FINISH;
            else if (w_rd_rise) w_state_nxt = CHECK;
            else if (w_tmr_tc)  w_state_nxt = FINISH;
         end
         CHECK: w_state_nxt = NEXT;
         NEXT: begin
            if (w_abort_any || (r_row == r_last_row)) begin
               w_state_nxt = FINISH;
            end else begin
               w_row_nxt   = r_row + 6'd1;
               w_state_nxt = SETUP_W;
            end
         end
         FINISH:  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_100m or negedge rst_n_locked) begin
      if (!rst_n_locked) begin
         r_state <= IDLE;
         r_row   <= '0;
         r_tmr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_row   <= w_row_nxt;
         // One down-counter serves both the setup hold and the completion timeout.
         if (w_state_nxt != r_state) begin
            case (w_state_nxt)
               SETUP_W, SETUP_R: r_tmr <= SETUP_LD;
               WAIT_W, WAIT_R:   r_tmr <= TO_LD;
               default:          r_tmr <= '0;
            endcase
         end else if (!w_tmr_tc) begin
            r_tmr <= r_tmr - TMR_W'(1);
         end
      end
   end

   always_ff @(posedge clk_100m or negedge rst_n_locked) begin
      if (!rst_n_locked) begin
         r_wt_prev <= 1'b0;
         r_rd_prev <= 1'b0;
      end else begin
         r_wt_prev <= wt_done;
         r_rd_prev <= rd_done;
      end
   end

   always_ff @(posedge clk_100m or negedge rst_n_locked) begin
      if (!rst_n_locked) begin
         r_last_row  <= '0;
         r_abort     <= 1'b0;
         r_err_cnt   <= '0;
         r_fail_row  <= 6'h3F;
         r_fail_seen <= 1'b0;
         r_timeout   <= 1'b0;
         r_pass      <= 1'b0;
      end else begin
         if (w_start_acc) begin
            r_last_row  <= cfg_last_row;
            r_abort     <= 1'b0;
            r_err_cnt   <= '0;
            r_fail_row  <= 6'h3F;
            r_fail_seen <= 1'b0;
            r_timeout   <= 1'b0;
            r_pass      <= 1'b0;
         end else begin
            if (r_state == FINISH)                      r_abort <= 1'b0;
            else if (abort && (r_state != IDLE))        r_abort <= 1'b1;

            if (r_state == CHECK) begin
               r_err_cnt <= w_err_sum[12] ? 12'hFFF : w_err_sum[11:0];
               if ((w_mis_cnt != '0) && !r_fail_seen) begin
                  r_fail_row  <= r_row;
                  r_fail_seen <= 1'b1;
               end
            end

            if (w_to_hit) r_timeout <= 1'b1;

            // Resolved on entry to FINISH so pass is valid alongside the done pulse.
            if ((w_state_nxt == FINISH) && (r_state != FINISH)) begin
               r_pass <= !w_abort_any && !w_to_hit && !r_timeout && (r_err_cnt == '0);
            end
         end
      end
   end

   always_ff @(posedge clk_100m or negedge rst_n_locked) begin
      if (!rst_n_locked) begin
         r_io_model    <= 2'b00;
         r_wwl_add     <= '0;
         r_rwl_dec_add <= '0;
         r_wbl_data    <= '0;
      end else begin
         if ((w_state_nxt == SETUP_W) && (r_state != SETUP_W)) begin
            r_io_model <= 2'b00;
            r_wwl_add  <= w_row_nxt;
            r_wbl_data <= {8{SEED ^ {2'b00, w_row_nxt}}};
         end
         if ((w_state_nxt == SETUP_R) && (r_state != SETUP_R)) begin
            r_io_model    <= 2'b01;
            r_rwl_dec_add <= r_row;
         end
      end
   end

   assign io_en       = (r_state == STROBE_W) || (r_state == STROBE_R);
   assign done        = (r_state == FINISH);
   assign busy        = (r_state != IDLE) && (r_state != FINISH);
   assign io_model    = r_io_model;
   assign wwl_add     = r_wwl_add;
   assign rwl_dec_add = r_rwl_dec_add;
   assign wbl_data    = r_wbl_data;
   assign pass        = r_pass;
   assign err_cnt     = r_err_cnt;
   assign fail_row    = r_fail_row;
   assign timeout     = r_timeout;

endmodule
